// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller wrapped around a single-cycle MIPS ALU.
//
// Accepts one R-type instruction word per handshake. Each instruction then takes
// a fixed three-state trip IDLE -> EXEC -> WB.
//
// EXEC: operands are read from the internal register file and presented to the
//       ALU. The ALU result and flags are captured at the edge that leaves EXEC.
// WB:   the result is written back to rd, or a jump target is emitted for jr.
//       The done/illegal/jump pulses are registered, so they appear in the IDLE
//       cycle that follows WB, together with instr_ready=1.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   instr_valid/instr_ready/instr  instruction handshake and word
//   ld_en/ld_addr/ld_data        register preload (register 0 ignored)
//   alu_reg_one/two/op/shamt     ALU drive (held outside EXEC)
//   alu_result, alu_* flags      ALU response
//   done/illegal/jump_valid      one-cycle retire pulses
//   jump_addr                    jr target, valid with jump_valid
//   flags                        {zero,negative,overflow,carry} of last legal write
//   dbg_addr/dbg_data            combinational register read
module alu_issue_ctrl #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  input  logic          ld_en,
  input  logic [4:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_reg_one,
  output logic [DW-1:0] alu_reg_two,
  output logic [5:0]    alu_op,
  output logic [4:0]    alu_shamt,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  input  logic          alu_carry,
  output logic          done,
  output logic          illegal,
  output logic          jump_valid,
  output logic [DW-1:0] jump_addr,
  output logic [3:0]    flags,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  localparam logic [5:0] FnJr = 6'd8;

  logic [1:0]    state_q, state_d;
  logic [5:0]    opcode_q, funct_q;
  logic [4:0]    rs_q, rt_q, rd_q, shamt_q;
  logic [DW-1:0] result_q;
  logic [3:0]    flags_cap_q, flags_q;
  logic [DW-1:0] regs_q [NREG];

  logic [DW-1:0] alu_one_q, alu_two_q;
  logic [5:0]    alu_op_q;
  logic [4:0]    alu_shamt_q;
  logic          done_q, illegal_q, jump_valid_q;
  logic [DW-1:0] jump_addr_q;

  logic          accept;
  logic          is_shift, is_legal, is_jr, wb_we;
  logic [DW-1:0] rd_rs, rd_rt, op_one, op_two;

  assign accept = instr_valid && (state_q == StIdle);

  // Decode off the latched fields so the result is stable through EXEC and WB.
  always_comb begin
    is_shift = (funct_q == 6'd0) || (funct_q == 6'd2) || (funct_q == 6'd3);
    is_legal = 1'b0;
    if (opcode_q == 6'd0) begin
      unique case (funct_q)
        6'd0, 6'd2, 6'd3, 6'd8, 6'd32, 6'd34,
        6'd36, 6'd37, 6'd38, 6'd39, 6'd42: is_legal = 1'b1;
        default:                           is_legal = 1'b0;
      endcase
    end
    is_jr = is_legal && (funct_q == FnJr);
    wb_we = (state_q == StWb) && is_legal && !is_jr && (rd_q != 5'd0);
  end

  // Register 0 reads as zero regardless of its storage.
  always_comb begin
    rd_rs    = (rs_q == 5'd0) ? '0 : regs_q[rs_q];
    rd_rt    = (rt_q == 5'd0) ? '0 : regs_q[rt_q];
    dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
    op_one   = is_shift ? rd_rt : rd_rs;
    op_two   = is_shift ? '0 : rd_rt;
  end

  // Live values during EXEC; outside EXEC the ALU sees the values from the last EXEC.
  always_comb begin
    if (state_q == StExec) begin
      alu_reg_one = op_one;
      alu_reg_two = op_two;
      alu_op      = funct_q;
      alu_shamt   = shamt_q;
    end else begin
      alu_reg_one = alu_one_q;
      alu_reg_two = alu_two_q;
      alu_op      = alu_op_q;
      alu_shamt   = alu_shamt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign instr_ready = (state_q == StIdle);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign jump_valid  = jump_valid_q;
  assign jump_addr   = jump_addr_q;
  assign flags       = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      opcode_q     <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      funct_q      <= '0;
      result_q     <= '0;
      flags_cap_q  <= '0;
      flags_q      <= '0;
      alu_one_q    <= '0;
      alu_two_q    <= '0;
      alu_op_q     <= '0;
      alu_shamt_q  <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      jump_valid_q <= 1'b0;
      jump_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      jump_valid_q <= 1'b0;
      if (accept) begin
        opcode_q <= instr[31:26];
        rs_q     <= instr[25:21];
        rt_q     <= instr[20:16];
        rd_q     <= instr[15:11];
        shamt_q  <= instr[10:6];
        funct_q  <= instr[5:0];
      end
      if (state_q == StExec) begin
        result_q    <= alu_result;
        flags_cap_q <= {alu_zero, alu_negative, alu_overflow, alu_carry};
        alu_one_q   <= op_one;
        alu_two_q   <= op_two;
        alu_op_q    <= funct_q;
        alu_shamt_q <= shamt_q;
      end
      if (state_q == StWb) begin
        if (!is_legal) begin
          illegal_q <= 1'b1;
        end else if (is_jr) begin
          done_q       <= 1'b1;
          jump_valid_q <= 1'b1;
          jump_addr_q  <= result_q;
        end else begin
          done_q <= 1'b1;
          if (rd_q != 5'd0) flags_q <= flags_cap_q;
        end
      end
    end
  end

  // Register file: writeback is applied after preload so it wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (ld_en && (ld_addr != 5'd0)) regs_q[ld_addr] <= ld_data;
      if (wb_we) regs_q[rd_q] <= result_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] alu_reg_one, alu_reg_two;
  logic [5:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero, alu_negative, alu_overflow, alu_carry;
  logic        done, illegal, jump_valid;
  logic [31:0] jump_addr;
  logic [3:0]  flags;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREG(32), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_reg_one  (alu_reg_one),
    .alu_reg_two  (alu_reg_two),
    .alu_op       (alu_op),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .done         (done),
    .illegal      (illegal),
    .jump_valid   (jump_valid),
    .jump_addr    (jump_addr),
    .flags        (flags),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Behavioural single-cycle ALU; carry on subtract means borrow.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_op)
      6'd0:  alu_result = alu_reg_one << alu_shamt;
      6'd2:  alu_result = alu_reg_one >> alu_shamt;
      6'd3:  alu_result = $unsigned($signed(alu_reg_one) >>> alu_shamt);
      6'd8:  alu_result = alu_reg_one;
      6'd32: begin
        {alu_carry, alu_result} = {1'b0, alu_reg_one} + {1'b0, alu_reg_two};
        alu_overflow = (alu_reg_one[31] == alu_reg_two[31]) && (alu_result[31] != alu_reg_one[31]);
      end
      6'd34: begin
        alu_result   = alu_reg_one - alu_reg_two;
        alu_carry    = alu_reg_one < alu_reg_two;
        alu_overflow = (alu_reg_one[31] != alu_reg_two[31]) && (alu_result[31] != alu_reg_one[31]);
      end
      6'd36: alu_result = alu_reg_one & alu_reg_two;
      6'd37: alu_result = alu_reg_one | alu_reg_two;
      6'd38: alu_result = alu_reg_one ^ alu_reg_two;
      6'd39: alu_result = ~(alu_reg_one | alu_reg_two);
      6'd42: alu_result = {31'd0, $signed(alu_reg_one) < $signed(alu_reg_two)};
      default: alu_result = '0;
    endcase
    alu_zero     = (alu_result == '0);
    alu_negative = alu_result[31];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check_eq(tag, dbg_data, exp);
  endtask

  // Issue one instruction and check EXEC operands plus the retire pulse timing.
  task automatic run_instr(input string tag, input logic [31:0] w, input logic [31:0] e_one,
                           input logic [31:0] e_two, input logic [2:0] e_pulse);
    int n = 0;
    @(negedge clk);
    instr = w; instr_valid = 1'b1;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      n_cmp++; n_err++;
      $display("FAIL %s accept: instr_ready stayed 0, expected 1", tag);
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq({tag, " exec one"}, alu_reg_one, e_one);
    check_eq({tag, " exec two"}, alu_reg_two, e_two);
    check_eq({tag, " exec ready"}, {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check_eq({tag, " wb pulses"}, {29'd0, done, illegal, jump_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, " retire pulses"}, {29'd0, done, illegal, jump_valid}, {29'd0, e_pulse});
    check_eq({tag, " retire ready"}, {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    check_eq({tag, " pulse width"}, {29'd0, done, illegal, jump_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    // Reset state
    #12;
    check_eq("rst ready", {31'd0, instr_ready}, 32'd1);
    check_eq("rst pulses", {29'd0, done, illegal, jump_valid}, 32'd0);
    check_eq("rst jump_addr", jump_addr, 32'd0);
    check_eq("rst alu_one", alu_reg_one, 32'd0);
    check_eq("rst alu_op", {21'd0, alu_op, alu_shamt}, 32'd0);
    check_eq("rst flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add R3 = 5 + 7
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    run_instr("add", rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32), 32'd5, 32'd7, 3'b100);
    reg_check("add r3", 5'd3, 32'd12);
    check_eq("add flags", {28'd0, flags}, 32'h0);

    // sll R6 = R5 << 4; operand one comes from rt, operand two is 0
    preload(5'd5, 32'd1);
    run_instr("sll", rtype(6'd0, 5'd0, 5'd5, 5'd6, 5'd4, 6'd0), 32'd1, 32'd0, 3'b100);
    reg_check("sll r6", 5'd6, 32'h10);
    check_eq("sll hold shamt", {27'd0, alu_shamt}, 32'd4);
    check_eq("sll hold one", alu_reg_one, 32'd1);

    // sub R4 = 3 - 3 -> zero flag
    preload(5'd1, 32'd3);
    preload(5'd2, 32'd3);
    preload(5'd4, 32'hdead);
    run_instr("sub", rtype(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'd34), 32'd3, 32'd3, 3'b100);
    reg_check("sub r4", 5'd4, 32'd0);
    check_eq("sub flags", {28'd0, flags}, 32'h8);

    // jr R7, rd field nonzero must still not be written
    preload(5'd7, 32'h0040_0000);
    run_instr("jr", rtype(6'd0, 5'd7, 5'd0, 5'd8, 5'd0, 6'd8), 32'h0040_0000, 32'd0, 3'b101);
    check_eq("jr addr", jump_addr, 32'h0040_0000);
    reg_check("jr r8", 5'd8, 32'd0);
    check_eq("jr flags", {28'd0, flags}, 32'h8);

    // Illegal opcode and illegal funct
    run_instr("bad opcode", rtype(6'd8, 5'd1, 5'd2, 5'd9, 5'd0, 6'd32), 32'd3, 32'd3, 3'b010);
    reg_check("bad opcode r9", 5'd9, 32'd0);
    check_eq("bad opcode flags", {28'd0, flags}, 32'h8);
    run_instr("bad funct", rtype(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd24), 32'd3, 32'd3, 3'b010);
    reg_check("bad funct r9", 5'd9, 32'd0);
    check_eq("bad funct flags", {28'd0, flags}, 32'h8);

    // add to R0: retires, but neither R0 nor flags change
    run_instr("add r0", rtype(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd32), 32'd3, 32'd3, 3'b100);
    reg_check("add r0 r0", 5'd0, 32'd0);
    check_eq("add r0 flags", {28'd0, flags}, 32'h8);

    // Back-to-back: valid held high, second accepted three edges later
    @(negedge clk);
    instr = rtype(6'd0, 5'd1, 5'd2, 5'd11, 5'd0, 6'd32);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr = rtype(6'd0, 5'd3, 5'd1, 5'd12, 5'd0, 6'd34);
    check_eq("b2b a one", alu_reg_one, 32'd3);
    check_eq("b2b ready 1", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check_eq("b2b ready 2", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check_eq("b2b ready 3", {31'd0, instr_ready}, 32'd1);
    check_eq("b2b a done", {31'd0, done}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("b2b b one", alu_reg_one, 32'd12);
    check_eq("b2b b two", alu_reg_two, 32'd3);
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b b done", {31'd0, done}, 32'd1);
    reg_check("b2b r11", 5'd11, 32'd6);
    reg_check("b2b r12", 5'd12, 32'd9);
    check_eq("b2b flags", {28'd0, flags}, 32'h0);

    // Reset during EXEC aborts the instruction
    preload(5'd13, 32'h55);
    @(negedge clk);
    instr = rtype(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, 6'd32);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("abort exec ready", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("abort ready", {31'd0, instr_ready}, 32'd1);
    check_eq("abort alu_one", alu_reg_one, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pulses += int'(done) + int'(illegal) + int'(jump_valid);
    end
    check_eq("abort pulses", pulses, 32'd0);
    reg_check("abort r13", 5'd13, 32'd0);
    check_eq("abort flags", {28'd0, flags}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
